// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and width helpers for the parametrised sync FIFO
package sync_fifo_pkg;

    // Pointer width for a given depth. The occupancy count is one bit wider
    // so that it can represent DEPTH itself.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port
//
// Ports:
//   clk        clock, write on rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (combinational read)
//   o_rd_data  word at i_rd_addr
//
// No reset: contents are undefined until written.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, sticky errors, flush and optional FWFT
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   flush               clears pointers/count, ignores this cycle's wr_en/rd_en
//   wr_en, wr_data      write request and data
//   rd_en               read request (FWFT: pop head)
//   rd_data, rd_valid   read data and its qualifier
//   full, empty         count == DEPTH / count == 0
//   almost_full         count >= AF_THRESH
//   almost_empty        count <= AE_THRESH
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky rejected-write / rejected-read flags
//   clr_err             clears both sticky flags
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    localparam int PW       = ptr_w(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
            $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;
    fifo_status_t      w_status;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_wr_rej;
    logic              w_rd_rej;
    logic [DATA_W-1:0] w_ram_rd_data;

    always_comb begin
        w_status              = '0;
        w_status.full         = (r_count == C_DEPTH);
        w_status.empty        = (r_count == '0);
        w_status.almost_full  = (r_count >= C_AF);
        w_status.almost_empty = (r_count <= C_AE);
    end

    // A write into a full FIFO is allowed only alongside a read, which is
    // always accepted in that case since full implies non-empty. Flush
    // swallows both requests and suppresses their error reporting.
    always_comb begin
        w_rd_acc = !flush && rd_en && !w_status.empty;
        w_wr_acc = !flush && wr_en && (!w_status.full || rd_en);
        w_wr_rej = !flush && wr_en && !w_wr_acc;
        w_rd_rej = !flush && rd_en && !w_rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !clr_err) || w_wr_rej;
            r_underflow <= (r_underflow && !clr_err) || w_rd_rej;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so no
            // stale or unwritten RAM content leaks onto the output.
            assign rd_data  = w_status.empty ? '0 : w_ram_rd_data;
            assign rd_valid = !w_status.empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= w_ram_rd_data;
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
